// File: rtl/regfile_sb.sv
// Multi-port register file with an optional write-to-read bypass and a per-register
// busy scoreboard that is set at issue and cleared at writeback.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 3,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        w_en,
  input  logic [NUM_WR*ADDR_W-1:0] w_addr,
  input  logic [NUM_WR*DATA_W-1:0] w_data,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  output logic [NUM_RD-1:0]        r_busy,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Addresses past NUM_REGS only exist when NUM_REGS is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS[ADDR_W:0]);
  endfunction

  function automatic logic [ADDR_W-1:0] wa(input int i);
    return w_addr[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] ra(input int j);
    return r_addr[j*ADDR_W +: ADDR_W];
  endfunction

  // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (w_en[i] && in_range(wa(i))) regs[wa(i)] <= w_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Mark is applied after the clears so a new producer keeps the register busy.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_en[i] && in_range(wa(i))) busy_nxt[wa(i)] = 1'b0;
    end
    if (mark_en && in_range(mark_addr)) busy_nxt[mark_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

  always_comb begin
    r_data = '0;
    r_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (in_range(ra(j))) begin
        r_data[j*DATA_W +: DATA_W] = regs[ra(j)];
        r_busy[j]                  = busy_q[ra(j)];
        if (BYPASS != 0) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (w_en[i] && wa(i) == ra(j)) r_data[j*DATA_W +: DATA_W] = w_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share
// stimulus; expectations are queued per cycle and compared by a separate monitor.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int NW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     w_en;
  logic [NW*AW-1:0]  w_addr;
  logic [NW*DW-1:0]  w_data;
  logic [NR*AW-1:0]  r_addr;
  logic              mark_en;
  logic [AW-1:0]     mark_addr;
  logic [NR*DW-1:0]  r_data1, r_data0;
  logic [NR-1:0]     r_busy1, r_busy0;
  logic [15:0]       busy_vec1, busy_vec0;

  regfile_sb #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data(r_data1), .r_busy(r_busy1),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_vec(busy_vec1));

  regfile_sb #(.BYPASS(0)) dut_nob (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data(r_data0), .r_busy(r_busy0),
    .mark_en(mark_en), .mark_addr(mark_addr), .busy_vec(busy_vec0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 bypass r_data, 1 bypass r_busy, 2 bypass busy_vec, 3 non-bypass r_data
  typedef struct {
    int          cyc;
    int          kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_v(input int kind, input int port, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.port = port; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b0; w_en = '0; w_addr = '0; w_data = '0; r_addr = '0;
    mark_en = 1'b0; mark_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    logic [3:0] a4;
    a4 = a[3:0];
    w_en[p] = 1'b1;
    w_addr[p*AW +: AW] = a4;
    w_data[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    logic [3:0] a4;
    a4 = a[3:0];
    r_addr[p*AW +: AW] = a4;
  endtask

  task automatic mark(input int a);
    mark_en = 1'b1;
    mark_addr = a[3:0];
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0: act = r_data1[e.port*DW +: DW];
        1: act = {31'b0, r_busy1[e.port]};
        2: act = {16'b0, busy_vec1};
        default: act = r_data0[e.port*DW +: DW];
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation from cycle %0d seen at %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    rst = 1'b1; w_en = '0; w_addr = '0; w_data = '0; r_addr = '0;
    mark_en = 1'b0; mark_addr = '0;

    step(); rst = 1'b1; rd(0, 0);
    expect_v(2, 0, 32'h0, "reset_busy_vec");
    expect_v(0, 0, 32'h0, "reset_rdata");
    expect_v(1, 0, 32'h0, "reset_rbusy");

    step(); wr(0, 3, 32'hDEADBEEF); mark(3); rd(0, 3);
    expect_v(0, 0, 32'hDEADBEEF, "preload_bypass");
    expect_v(3, 0, 32'h0, "preload_nobypass");

    step(); rd(0, 3);
    expect_v(0, 0, 32'hDEADBEEF, "preload_stored");
    expect_v(3, 0, 32'hDEADBEEF, "preload_stored_nob");
    expect_v(2, 0, 32'h0008, "preload_busy_vec");
    expect_v(1, 0, 32'h1, "preload_rbusy");

    step(); rst = 1'b1; rd(0, 3);
    expect_v(0, 0, 32'hDEADBEEF, "rst_cycle_old_data");

    step(); rd(0, 3);
    expect_v(0, 0, 32'h0, "after_rst_rdata");
    expect_v(3, 0, 32'h0, "after_rst_rdata_nob");
    expect_v(2, 0, 32'h0, "after_rst_busy_vec");
    expect_v(1, 0, 32'h0, "after_rst_rbusy");

    step(); wr(0, 5, 32'h11111111); wr(1, 5, 32'h22222222); wr(2, 5, 32'h33333333); rd(1, 5);
    expect_v(0, 1, 32'h33333333, "conflict_bypass");
    expect_v(3, 1, 32'h0, "conflict_nobypass");

    step(); rd(1, 5);
    expect_v(0, 1, 32'h33333333, "conflict_stored");
    expect_v(3, 1, 32'h33333333, "conflict_stored_nob");

    step(); wr(0, 1, 32'hA); wr(1, 2, 32'hB); wr(2, 14, 32'hC);
    rd(0, 1); rd(1, 2); rd(2, 14); rd(3, 0);
    expect_v(0, 0, 32'hA, "par_byp_p0");
    expect_v(0, 1, 32'hB, "par_byp_p1");
    expect_v(0, 2, 32'hC, "par_byp_p2");
    expect_v(0, 3, 32'h0, "par_byp_p3");

    step(); rd(0, 1); rd(1, 2); rd(2, 14); rd(3, 0);
    for (int p = 0; p < 2; p++) begin
      expect_v(p * 3, 0, 32'hA, "par_p0");
      expect_v(p * 3, 1, 32'hB, "par_p1");
      expect_v(p * 3, 2, 32'hC, "par_p2");
      expect_v(p * 3, 3, 32'h0, "par_p3");
    end

    step(); wr(0, 7, 32'h42); rd(2, 7);
    expect_v(0, 2, 32'h42, "byp7_same_cycle");
    expect_v(3, 2, 32'h0, "nob7_same_cycle");

    step(); rd(2, 7);
    expect_v(0, 2, 32'h42, "byp7_next");
    expect_v(3, 2, 32'h42, "nob7_next");

    step(); mark(4); rd(3, 4);
    expect_v(1, 3, 32'h0, "mark4_not_yet");

    step(); rd(3, 4); wr(1, 4, 32'h5);
    expect_v(1, 3, 32'h1, "mark4_rbusy");
    expect_v(2, 0, 32'h0010, "mark4_busy_vec");

    step(); rd(3, 4);
    expect_v(0, 3, 32'h5, "wb4_data");
    expect_v(1, 3, 32'h0, "wb4_rbusy");
    expect_v(2, 0, 32'h0, "wb4_busy_vec");

    step(); mark(9);

    step(); wr(2, 9, 32'h77); mark(9);
    expect_v(2, 0, 32'h0200, "mark9_busy_vec");

    step(); rd(0, 9);
    expect_v(2, 0, 32'h0200, "collide9_busy_vec");
    expect_v(0, 0, 32'h77, "collide9_data");
    expect_v(3, 0, 32'h77, "collide9_data_nob");
    expect_v(1, 0, 32'h1, "collide9_rbusy");

    step(); rst = 1'b1; wr(0, 6, 32'h99); rd(1, 6);
    expect_v(0, 1, 32'h99, "rst_bypass_fwd");
    expect_v(3, 1, 32'h0, "rst_nobypass");

    step(); rd(0, 9); rd(1, 6);
    expect_v(2, 0, 32'h0, "rst9_busy_vec");
    expect_v(0, 0, 32'h0, "rst9_data");
    expect_v(0, 1, 32'h0, "rst6_not_stored");
    expect_v(3, 1, 32'h0, "rst6_not_stored_nob");

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file for the ARM32 datapath. It generalises the fixed 16x32 file with three write ports and four read ports.
- Adds synchronous reset, configurable width, depth and port counts, and optional write-to-read bypass.
- Adds a per-register busy scoreboard. The pipeline sets a bit when an instruction issues with a pending destination and clears it when that result is written back.
- Sits between decode/issue (read and mark side) and writeback (write side).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of registers; ADDR_W = $clog2(NUM_REGS), derived localparam.
- NUM_RD, 4, number of read ports (A, B, shift, str in the default configuration).
- NUM_WR, 3, number of write ports.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored contents only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  NUM_WR  write enable per port.
- w_addr  in  NUM_WR*ADDR_W  write address; port i occupies slice [i*ADDR_W +: ADDR_W].
- w_data  in  NUM_WR*DATA_W  write data; port i occupies slice [i*DATA_W +: DATA_W].
- r_addr  in  NUM_RD*ADDR_W  read address per port.
- r_data  out  NUM_RD*DATA_W  read data per port, combinational.
- r_busy  out  NUM_RD  busy bit of the addressed register, combinational.
- mark_en  in  1  set the busy bit of mark_addr (destination reserved at issue).
- mark_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  NUM_REGS  full scoreboard, registered.

Behaviour:
- Reset: when rst=1 at posedge, all registers become 0 and busy_vec becomes 0.
  - Writes and marks in the same cycle are ignored.
  - Reset overrides any in-flight reservation.
  - After reset, every read returns 0 with r_busy=0, unless BYPASS forwards a write presented while rst is still asserted. Such a write is not stored.
- Write:
  - On posedge with rst=0, each port with w_en[i]=1 stores w_data[i] into reg[w_addr[i]].
  - Same-cycle conflict on one address: the highest-index port wins (port NUM_WR-1 has top priority). Losing ports have no effect.
  - Writes to distinct addresses all commit in the same cycle.
- Read:
  - Purely combinational, zero latency.
  - BYPASS=1: if any enabled write port targets r_addr[j] this cycle, r_data[j] = that port's w_data. If several ports target it, the highest-index port wins, matching the commit priority. Otherwise r_data[j] = the stored value.
  - BYPASS=0: r_data[j] = the stored value; new data is visible the cycle after the write.
  - Out-of-range addresses (NUM_REGS not a power of 2): r_data = 0 and r_busy = 0. Writes and marks to such addresses are dropped.
- Scoreboard: next busy[k] is computed as follows.
  - Clear: busy[k] is cleared if any enabled write port targets k.
  - Set: busy[k] is set if mark_en=1 and mark_addr=k.
  - Set has priority over clear. A write landing on the same cycle a new producer issues leaves the register busy.
  - Otherwise busy[k] holds.
  - r_busy[j] = busy_vec[r_addr[j]], using the registered value with no bypass of same-cycle set or clear. The issue logic treats a same-cycle write via bypassed data.
  - Marking an already-busy register keeps it busy; it is not an error.
- There is no internal state machine beyond the storage array and the NUM_REGS busy flops. Everything is single-cycle.

Test Plan:
- Reset clears: preload reg3=0xDEADBEEF and mark reg3, then assert rst for one cycle -> r_data(r_addr=3)=0x00000000, busy_vec=0x0000.
- Write conflict: port0 writes reg5=0x11111111, port1 reg5=0x22222222, port2 reg5=0x33333333 in the same cycle -> next cycle reg5 reads 0x33333333. With BYPASS=1, the same cycle already reads 0x33333333.
- Parallel writes: ports 0/1/2 write reg1=0xA, reg2=0xB, reg14=0xC -> next cycle four read ports on addresses 1, 2, 14, 0 return 0xA, 0xB, 0xC, 0x0.
- Bypass modes: BYPASS=1, write reg7=0x00000042 and read reg7 in the same cycle -> 0x42 combinationally. BYPASS=0 -> old value that cycle, 0x42 the next cycle.
- Scoreboard lifecycle: mark reg4 -> next cycle busy_vec[4]=1 and r_busy=1 on a port reading 4. Then write reg4=0x5 -> next cycle busy_vec[4]=0 and data 0x5.
- Mark/write collision: reg9 busy, then write reg9=0x77 with mark_en=1 and mark_addr=9 in the same cycle -> reg9=0x77 and busy_vec[9] stays 1. Reset mid-reservation -> busy_vec[9]=0.
